// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package    : riscv_pkg
// Description: RV32I opcode constants, decoded operation enum and the shared
//              operand-forwarding helper used by the decode stage.
// Revision   : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [OPW-1:0] {
        OP_NOP,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR
    } op_e;

    // EX result beats MEM result, which beats the register file / held copy.
    function automatic logic [XLEN-1:0] operand_fwd(
        input logic [4:0]      rs,
        input logic            first,
        input logic [XLEN-1:0] rn,
        input logic [XLEN-1:0] hold,
        input logic            exf_we,
        input logic [4:0]      exf_wa,
        input logic [XLEN-1:0] exf_wn,
        input logic            memf_we,
        input logic [4:0]      memf_wa,
        input logic [XLEN-1:0] memf_wn
    );
        logic [XLEN-1:0] v;
        if (rs == 5'd0)
            v = '0;
        else if (exf_we && (exf_wa == rs))
            v = exf_wn;
        else if (memf_we && (memf_wa == rs))
            v = memf_wn;
        else
            v = first ? rn : hold;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decoder.sv
`default_nettype none
// ============================================================================
// Module     : id_decoder
// Description: Combinational RV32I instruction decoder (op, rd, imm, rs usage).
// Revision   : 1.0 - initial release
// ============================================================================
module id_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]     inst_i,
    output op_e             op_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            uses_rs1_o,
    output logic            uses_rs2_o
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_has_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    assign w_opc = inst_i[6:0];
    assign w_f3  = inst_i[14:12];
    assign w_f7  = inst_i[31:25];

    assign w_imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign w_imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign w_imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign w_imm_u  = {inst_i[31:12], 12'b0};
    assign w_imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign w_imm_sh = {27'b0, inst_i[24:20]};

    assign rs1_o = inst_i[19:15];
    assign rs2_o = inst_i[24:20];

    always_comb begin
        op_o = OP_NOP;
        case (w_opc)
            OPC_LUI:   op_o = OP_LUI;
            OPC_AUIPC: op_o = OP_AUIPC;
            OPC_JAL:   op_o = OP_JAL;
            OPC_JALR:  if (w_f3 == 3'b000) op_o = OP_JALR;
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000:  op_o = OP_BEQ;
                    3'b001:  op_o = OP_BNE;
                    3'b100:  op_o = OP_BLT;
                    3'b101:  op_o = OP_BGE;
                    3'b110:  op_o = OP_BLTU;
                    3'b111:  op_o = OP_BGEU;
                    default: op_o = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                case (w_f3)
                    3'b000:  op_o = OP_LB;
                    3'b001:  op_o = OP_LH;
                    3'b010:  op_o = OP_LW;
                    3'b100:  op_o = OP_LBU;
                    3'b101:  op_o = OP_LHU;
                    default: op_o = OP_NOP;
                endcase
            end
            OPC_STORE: begin
                case (w_f3)
                    3'b000:  op_o = OP_SB;
                    3'b001:  op_o = OP_SH;
                    3'b010:  op_o = OP_SW;
                    default: op_o = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                case (w_f3)
                    3'b000:  op_o = OP_ADDI;
                    3'b010:  op_o = OP_SLTI;
                    3'b011:  op_o = OP_SLTIU;
                    3'b100:  op_o = OP_XORI;
                    3'b110:  op_o = OP_ORI;
                    3'b111:  op_o = OP_ANDI;
                    3'b001:  op_o = (w_f7 == F7_BASE) ? OP_SLLI : OP_NOP;
                    default: op_o = (w_f7 == F7_BASE) ? OP_SRLI :
                                    (w_f7 == F7_ALT)  ? OP_SRAI : OP_NOP;
                endcase
            end
            OPC_OP: begin
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'b000:  op_o = OP_ADD;
                        3'b001:  op_o = OP_SLL;
                        3'b010:  op_o = OP_SLT;
                        3'b011:  op_o = OP_SLTU;
                        3'b100:  op_o = OP_XOR;
                        3'b101:  op_o = OP_SRL;
                        3'b110:  op_o = OP_OR;
                        default: op_o = OP_AND;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == 3'b000)
                        op_o = OP_SUB;
                    else if (w_f3 == 3'b101)
                        op_o = OP_SRA;
                end
            end
            default: op_o = OP_NOP;
        endcase
    end

    // Field extraction keyed off the final op so illegal encodings yield nothing.
    always_comb begin
        w_has_rd   = 1'b0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        imm_o      = '0;
        case (op_o)
            OP_LUI, OP_AUIPC: begin
                w_has_rd = 1'b1;
                imm_o    = w_imm_u;
            end
            OP_JAL: begin
                w_has_rd = 1'b1;
                imm_o    = w_imm_j;
            end
            OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                w_has_rd   = 1'b1;
                uses_rs1_o = 1'b1;
                imm_o      = w_imm_i;
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                w_has_rd   = 1'b1;
                uses_rs1_o = 1'b1;
                imm_o      = w_imm_sh;
            end
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
                w_has_rd   = 1'b1;
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                imm_o      = w_imm_s;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                imm_o      = w_imm_b;
            end
            default: w_has_rd = 1'b0;
        endcase
    end

    assign rd_o = w_has_rd ? inst_i[11:7] : 5'd0;
    assign we_o = w_has_rd && (inst_i[11:7] != 5'd0);

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module     : id_stage
// Description: RV32I decode stage with synchronous RF read, EX/MEM forwarding,
//              load-use stall and valid/ready handoff to EX.
// Revision   : 1.0 - initial release
// ============================================================================
module id_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    output logic            rf_re1,
    output logic            rf_re2,
    input  logic [XLEN-1:0] rf_rn1,
    input  logic [XLEN-1:0] rf_rn2,
    input  logic            exf_we,
    input  logic [4:0]      exf_wa,
    input  logic [XLEN-1:0] exf_wn,
    input  logic            exf_load,
    input  logic            memf_we,
    input  logic [4:0]      memf_wa,
    input  logic [XLEN-1:0] memf_wn,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output op_e             ex_op,
    output logic [XLEN-1:0] ex_rs1v,
    output logic [XLEN-1:0] ex_rs2v,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_we
);

    op_e             dec_op;
    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic            dec_we, dec_use1, dec_use2;
    logic [XLEN-1:0] dec_imm;

    id_decoder u_dec (
        .inst_i     (if_inst),
        .op_o       (dec_op),
        .rd_o       (dec_rd),
        .we_o       (dec_we),
        .imm_o      (dec_imm),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .uses_rs1_o (dec_use1),
        .uses_rs2_o (dec_use2)
    );

    logic            s2_valid_q, s2_valid_d;
    logic            s2_first_q, s2_first_d;
    logic [XLEN-1:0] pc_q, pc_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [XLEN-1:0] hold1_q, hold1_d;
    logic [XLEN-1:0] hold2_q, hold2_d;

    logic [XLEN-1:0] opnd1, opnd2;
    logic            stall, ex_fire, accept;

    assign opnd1 = operand_fwd(rs1_q, s2_first_q, rf_rn1, hold1_q,
                               exf_we, exf_wa, exf_wn, memf_we, memf_wa, memf_wn);
    assign opnd2 = operand_fwd(rs2_q, s2_first_q, rf_rn2, hold2_q,
                               exf_we, exf_wa, exf_wn, memf_we, memf_wa, memf_wn);

    // Unused source indices are stored as x0, so they can never trigger a stall.
    assign stall    = exf_load && exf_we && (exf_wa != 5'd0) &&
                      ((exf_wa == rs1_q) || (exf_wa == rs2_q));
    assign ex_valid = s2_valid_q && !stall && !flush && !rst;
    assign ex_fire  = ex_valid && ex_ready;
    assign if_ready = !rst && !flush && (!s2_valid_q || ex_fire);
    assign accept   = if_valid && if_ready;

    assign rf_ra1 = rst ? 5'd0 : dec_rs1;
    assign rf_ra2 = rst ? 5'd0 : dec_rs2;
    assign rf_re1 = accept && dec_use1;
    assign rf_re2 = accept && dec_use2;

    assign ex_pc   = pc_q;
    assign ex_op   = op_q;
    assign ex_imm  = imm_q;
    assign ex_rd   = rd_q;
    assign ex_we   = we_q;
    assign ex_rs1v = opnd1;
    assign ex_rs2v = opnd2;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_first_d = s2_first_q;
        pc_d       = pc_q;
        op_d       = op_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        we_d       = we_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        hold1_d    = hold1_q;
        hold2_d    = hold2_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (accept) begin
            s2_valid_d = 1'b1;
            s2_first_d = 1'b1;
            pc_d       = if_pc;
            op_d       = dec_op;
            imm_d      = dec_imm;
            rd_d       = dec_rd;
            we_d       = dec_we;
            rs1_d      = dec_use1 ? dec_rs1 : 5'd0;
            rs2_d      = dec_use2 ? dec_rs2 : 5'd0;
        end else if (ex_fire) begin
            s2_valid_d = 1'b0;
        end else if (s2_valid_q) begin
            // RF data is only valid for one cycle; keep the forwarded view.
            hold1_d    = opnd1;
            hold2_d    = opnd2;
            s2_first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            pc_q       <= '0;
            op_q       <= OP_NOP;
            imm_q      <= '0;
            rd_q       <= 5'd0;
            we_q       <= 1'b0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            hold1_q    <= '0;
            hold2_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_first_q <= s2_first_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            hold1_q    <= hold1_d;
            hold2_q    <= hold2_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module     : tb_id_stage
// Description: Self-checking bench for id_stage (vector table + scoreboard).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_id_stage;
    import riscv_pkg::*;

    logic        clk, rst, flush, if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic [4:0]  rf_ra1, rf_ra2;
    logic        rf_re1, rf_re2;
    logic [31:0] rf_rn1, rf_rn2;
    logic        exf_we, exf_load, memf_we;
    logic [4:0]  exf_wa, memf_wa;
    logic [31:0] exf_wn, memf_wn;
    logic        ex_valid, ex_ready, ex_we;
    logic [31:0] ex_pc, ex_rs1v, ex_rs2v, ex_imm;
    op_e         ex_op;
    logic [4:0]  ex_rd;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_re1(rf_re1), .rf_re2(rf_re2),
        .rf_rn1(rf_rn1), .rf_rn2(rf_rn2),
        .exf_we(exf_we), .exf_wa(exf_wa), .exf_wn(exf_wn), .exf_load(exf_load),
        .memf_we(memf_we), .memf_wa(memf_wa), .memf_wn(memf_wn),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op(ex_op),
        .ex_rs1v(ex_rs1v), .ex_rs2v(ex_rs2v), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_we(ex_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        op_e         op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rn1;
        logic [31:0] rn2;
        logic        re1;
        logic        re2;
        exp_t        e;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vt [NVEC];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input op_e op, input logic [31:0] imm,
                                    input logic [4:0] rd, input logic we,
                                    input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        e.pc = pc; e.op = op; e.imm = imm; e.rd = rd; e.we = we; e.v1 = v1; e.v2 = v2;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] inst, input logic [31:0] rn1,
                                    input logic [31:0] rn2, input logic re1, input logic re2,
                                    input op_e op, input logic [31:0] imm, input logic [4:0] rd,
                                    input logic we, input logic [31:0] v1, input logic [31:0] v2);
        vec_t v;
        v.inst = inst; v.rn1 = rn1; v.rn2 = rn2; v.re1 = re1; v.re2 = re2;
        v.e = mk_exp(32'h0, op, imm, rd, we, v1, v2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic pop_cmp(input string nm);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s.sb: got empty scoreboard want entry", nm);
            return;
        end
        e = sbq.pop_front();
        chk({nm, ".pc"},   ex_pc, e.pc);
        chk({nm, ".op"},   32'(ex_op), 32'(e.op));
        chk({nm, ".imm"},  ex_imm, e.imm);
        chk({nm, ".rd"},   32'(ex_rd), 32'(e.rd));
        chk({nm, ".we"},   32'(ex_we), 32'(e.we));
        chk({nm, ".rs1v"}, ex_rs1v, e.v1);
        chk({nm, ".rs2v"}, ex_rs2v, e.v2);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk_vec(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h123, 32'h456, 1, 0,
                        OP_ADDI, 32'd5, 5'd1, 1, 32'h0, 32'h0);
        vt[1]  = mk_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h11, 32'h22, 1, 1,
                        OP_ADD, 32'h0, 5'd3, 1, 32'h11, 32'h22);
        vt[2]  = mk_vec(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 7'h33), 32'd100, 32'd30, 1, 1,
                        OP_SUB, 32'h0, 5'd5, 1, 32'd100, 32'd30);
        vt[3]  = mk_vec(enc_u(20'h12345, 5'd8, 7'h37), 32'hAA, 32'hBB, 0, 0,
                        OP_LUI, 32'h12345000, 5'd8, 1, 32'h0, 32'h0);
        vt[4]  = mk_vec(enc_s(12'hFF8, 5'd9, 5'd10, 3'b010), 32'h1000, 32'hDEAD, 1, 1,
                        OP_SW, 32'hFFFFFFF8, 5'd0, 0, 32'h1000, 32'hDEAD);
        vt[5]  = mk_vec(enc_b(13'h10, 5'd2, 5'd1, 3'b001), 32'd5, 32'd6, 1, 1,
                        OP_BNE, 32'h10, 5'd0, 0, 32'd5, 32'd6);
        vt[6]  = mk_vec(enc_j(21'h800, 5'd1), 32'h1, 32'h2, 0, 0,
                        OP_JAL, 32'h800, 5'd1, 1, 32'h0, 32'h0);
        vt[7]  = mk_vec(enc_i(12'd12, 5'd2, 3'b010, 5'd4, 7'h03), 32'h80, 32'h99, 1, 0,
                        OP_LW, 32'd12, 5'd4, 1, 32'h80, 32'h0);
        vt[8]  = mk_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'd1, 32'd2, 1, 1,
                        OP_ADD, 32'h0, 5'd0, 0, 32'd1, 32'd2);
        vt[9]  = mk_vec(32'hFFFFFFFF, 32'h5, 32'h6, 0, 0,
                        OP_NOP, 32'h0, 5'd0, 0, 32'h0, 32'h0);
        vt[10] = mk_vec(enc_i(12'h403, 5'd4, 3'b101, 5'd3, 7'h13), 32'h80000000, 32'h7, 1, 0,
                        OP_SRAI, 32'd3, 5'd3, 1, 32'h80000000, 32'h0);
        vt[11] = mk_vec(enc_i(12'd4, 5'd5, 3'd0, 5'd1, 7'h67), 32'h2000, 32'h7, 1, 0,
                        OP_JALR, 32'd4, 5'd1, 1, 32'h2000, 32'h0);
        vt[12] = mk_vec(enc_u(20'hFFFFF, 5'd2, 7'h17), 32'h3, 32'h4, 0, 0,
                        OP_AUIPC, 32'hFFFFF000, 5'd2, 1, 32'h0, 32'h0);
        vt[13] = mk_vec(enc_i(12'hFFF, 5'd6, 3'b111, 5'd7, 7'h13), 32'h0F0F, 32'h1, 1, 0,
                        OP_ANDI, 32'hFFFFFFFF, 5'd7, 1, 32'h0F0F, 32'h0);
        vt[14] = mk_vec(enc_i(12'h021, 5'd1, 3'b001, 5'd2, 7'h13), 32'h3, 32'h4, 0, 0,
                        OP_NOP, 32'h0, 5'd0, 0, 32'h0, 32'h0);

        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        rf_rn1 = '0; rf_rn2 = '0;
        exf_we = 0; exf_wa = '0; exf_wn = '0; exf_load = 0;
        memf_we = 0; memf_wa = '0; memf_wn = '0;
        offer(enc_i(12'd5, 5'd2, 3'd0, 5'd1, 7'h13), 32'h44);

        // reset behaviour
        step;
        samp;
        chk("rst.if_ready", 32'(if_ready), 0);
        chk("rst.ex_valid", 32'(ex_valid), 0);
        chk("rst.rf_re1",   32'(rf_re1), 0);
        chk("rst.rf_ra1",   32'(rf_ra1), 0);
        chk("rst.ex_op",    32'(ex_op), 32'(OP_NOP));
        chk("rst.ex_pc",    ex_pc, 0);
        chk("rst.ex_imm",   ex_imm, 0);
        chk("rst.ex_we",    32'(ex_we), 0);
        step;
        rst = 1'b0; if_valid = 1'b0;

        // table-driven single instructions
        for (int i = 0; i < NVEC; i++) begin
            vt[i].e.pc = 32'h1000 + 32'(i * 4);
            offer(vt[i].inst, vt[i].e.pc);
            samp;
            chk($sformatf("v%0d.if_ready", i), 32'(if_ready), 1);
            chk($sformatf("v%0d.rf_re1", i), 32'(rf_re1), 32'(vt[i].re1));
            chk($sformatf("v%0d.rf_re2", i), 32'(rf_re2), 32'(vt[i].re2));
            chk($sformatf("v%0d.rf_ra1", i), 32'(rf_ra1), 32'(vt[i].inst[19:15]));
            chk($sformatf("v%0d.rf_ra2", i), 32'(rf_ra2), 32'(vt[i].inst[24:20]));
            sbq.push_back(vt[i].e);
            step;
            if_valid = 1'b0;
            rf_rn1 = vt[i].rn1;
            rf_rn2 = vt[i].rn2;
            samp;
            chk($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 1);
            pop_cmp($sformatf("v%0d", i));
            step;
        end

        // EX/MEM forwarding priority
        offer(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h700);
        sbq.push_back(mk_exp(32'h700, OP_ADD, 32'h0, 5'd3, 1, 32'd7, 32'd9));
        step;
        offer(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd3, 7'h33), 32'h704);
        rf_rn1 = 32'h55; rf_rn2 = 32'h66;
        exf_we = 1; exf_wa = 5'd1; exf_wn = 32'd7;
        memf_we = 1; memf_wa = 5'd2; memf_wn = 32'd9;
        samp;
        chk("fwd.ex_valid", 32'(ex_valid), 1);
        pop_cmp("fwd_ex_mem");
        sbq.push_back(mk_exp(32'h704, OP_ADD, 32'h0, 5'd3, 1, 32'd7, 32'd7));
        step;
        if_valid = 1'b0;
        memf_wa = 5'd1;
        samp;
        chk("fwd2.ex_valid", 32'(ex_valid), 1);
        pop_cmp("fwd_ex_wins");
        step;
        exf_we = 0; memf_we = 0;

        // load-use stall released by MEM forward
        offer(enc_r(7'h20, 5'd4, 5'd4, 3'd0, 5'd5, 7'h33), 32'h600);
        sbq.push_back(mk_exp(32'h600, OP_SUB, 32'h0, 5'd5, 1, 32'h10, 32'h10));
        step;
        if_valid = 1'b0;
        rf_rn1 = 32'h99; rf_rn2 = 32'h99;
        exf_load = 1; exf_we = 1; exf_wa = 5'd4; exf_wn = 32'hBAD;
        samp;
        chk("lu1.ex_valid", 32'(ex_valid), 0);
        chk("lu1.if_ready", 32'(if_ready), 0);
        step;
        samp;
        chk("lu2.ex_valid", 32'(ex_valid), 0);
        step;
        exf_load = 0; exf_we = 0;
        memf_we = 1; memf_wa = 5'd4; memf_wn = 32'h10;
        samp;
        chk("lu3.ex_valid", 32'(ex_valid), 1);
        pop_cmp("load_use");
        step;
        memf_we = 0;

        // EX back-pressure: outputs hold for three cycles
        offer(enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h13), 32'h800);
        sbq.push_back(mk_exp(32'h800, OP_ADDI, 32'd1, 5'd2, 1, 32'hAA, 32'h0));
        step;
        offer(enc_i(12'd1, 5'd1, 3'd0, 5'd9, 7'h13), 32'h804);
        rf_rn1 = 32'hAA; ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            samp;
            chk($sformatf("bp%0d.ex_valid", c), 32'(ex_valid), 1);
            chk($sformatf("bp%0d.rs1v", c), ex_rs1v, 32'hAA);
            chk($sformatf("bp%0d.pc", c), ex_pc, 32'h800);
            chk($sformatf("bp%0d.imm", c), ex_imm, 32'd1);
            chk($sformatf("bp%0d.if_ready", c), 32'(if_ready), 0);
            chk($sformatf("bp%0d.rf_re1", c), 32'(rf_re1), 0);
            step;
            rf_rn1 = 32'h77;
        end
        if_valid = 1'b0; ex_ready = 1'b1;
        samp;
        chk("bp.release_valid", 32'(ex_valid), 1);
        pop_cmp("backpressure");
        step;

        // flush kills S2 and the offered instruction
        offer(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h900);
        step;
        offer(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h904);
        flush = 1'b1;
        samp;
        chk("fl.if_ready", 32'(if_ready), 0);
        chk("fl.rf_re1", 32'(rf_re1), 0);
        chk("fl.rf_re2", 32'(rf_re2), 0);
        step;
        flush = 1'b0; if_valid = 1'b0;
        samp;
        chk("fl.next_valid", 32'(ex_valid), 0);
        step;

        // reset in the middle of a load-use stall
        offer(enc_r(7'h20, 5'd4, 5'd4, 3'd0, 5'd5, 7'h33), 32'hA00);
        step;
        if_valid = 1'b0;
        exf_load = 1; exf_we = 1; exf_wa = 5'd4;
        samp;
        chk("rs.stall_valid", 32'(ex_valid), 0);
        step;
        rst = 1'b1;
        samp;
        chk("rs.in_rst_valid", 32'(ex_valid), 0);
        chk("rs.in_rst_ready", 32'(if_ready), 0);
        step;
        rst = 1'b0; exf_load = 0; exf_we = 0;
        offer(enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000), 32'hB00);
        samp;
        chk("rs.after_valid", 32'(ex_valid), 0);
        chk("rs.after_op", 32'(ex_op), 32'(OP_NOP));
        chk("rs.after_pc", ex_pc, 0);
        chk("rs.after_ready", 32'(if_ready), 1);
        chk("rs.beq_re1", 32'(rf_re1), 1);
        chk("rs.beq_re2", 32'(rf_re2), 1);
        sbq.push_back(mk_exp(32'hB00, OP_BEQ, 32'hFFFFFFFC, 5'd0, 0, 32'h0, 32'h0));
        step;
        if_valid = 1'b0;
        samp;
        chk("beq.ex_valid", 32'(ex_valid), 1);
        pop_cmp("beq_neg");
        step;

        chk("sb.leftover", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
